latency_data_memory: RTL and testbench

//  Word-array data memory for the multi-cycle/pipelined RV32 core; successor to the single-cycle data memory.

---
 rtl/mem_pkg.sv | 17 +
 rtl/load_store_align.sv | 60 ++++++
 rtl/latency_data_memory.sv | 200 ++++++++++++++++++++
 tb/tb_latency_data_memory.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for latency_data_memory: RV32 load/store funct3 codes
// and the access FSM state encoding.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: merges store data into the old word, extends
// load data, and flags misaligned or illegal funct3 accesses.
module load_store_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_write,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] store_word,
  output logic [31:0] load_data,
  output logic        fault
);

  logic [4:0]  byte_sh_s;
  logic [4:0]  half_sh_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection, store merge and load extension
  always_comb begin
    byte_sh_s  = {addr_lo, 3'b000};
    half_sh_s  = {addr_lo[1], 4'b0000};
    byte_s     = old_word[byte_sh_s +: 8];
    half_s     = old_word[half_sh_s +: 16];
    store_word = old_word;
    load_data  = 32'h0000_0000;
    fault      = 1'b0;
    case (funct3)
      F3_B: begin
        store_word[byte_sh_s +: 8] = wdata[7:0];
        load_data = {{24{byte_s[7]}}, byte_s};
      end
      F3_H: begin
        fault = addr_lo[0];
        store_word[half_sh_s +: 16] = wdata[15:0];
        load_data = {{16{half_s[15]}}, half_s};
      end
      F3_W: begin
        fault      = (addr_lo != 2'b00);
        store_word = wdata;
        load_data  = old_word;
      end
      // Unsigned variants exist only for loads
      F3_BU: begin
        fault     = is_write;
        load_data = {24'h00_0000, byte_s};
      end
      F3_HU: begin
        fault     = is_write | addr_lo[0];
        load_data = {16'h0000, half_s};
      end
      default: begin
        fault = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/latency_data_memory.sv
// Word-array data memory with valid/ready handshake, programmable access
// latency and byte/halfword/word accesses selected by RV32 funct3.
module latency_data_memory
  import mem_pkg::*;
#(
  parameter int MEM_DEPTH = 16384,
  parameter int LATENCY   = 2,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_error
);

  localparam int         IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_error_q, resp_error_d;

  logic [31:0]       mem_q [MEM_DEPTH];

  logic [ADDR_W-1:0] acc_addr_s;
  logic              acc_write_s;
  logic [2:0]        acc_funct3_s;
  logic [31:0]       acc_wdata_s;
  logic [ADDR_W-1:0] word_idx_s;
  logic [IDX_W-1:0]  mem_idx_s;
  logic              oor_s;
  logic [31:0]       old_word_s;
  logic [31:0]       store_word_s;
  logic [31:0]       load_data_s;
  logic              fault_s;
  logic              err_s;
  logic              commit_s;
  logic              mem_we_s;

  // With LATENCY==1 the commit edge is the acceptance edge, so the live request feeds the access path
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_addr_s   = req_addr;
      acc_write_s  = req_write;
      acc_funct3_s = req_funct3;
      acc_wdata_s  = req_wdata;
    end else begin
      acc_addr_s   = addr_q;
      acc_write_s  = write_q;
      acc_funct3_s = funct3_q;
      acc_wdata_s  = wdata_q;
    end
    word_idx_s = acc_addr_s >> 2;
    mem_idx_s  = word_idx_s[IDX_W-1:0];
    oor_s      = (word_idx_s >= ADDR_W'(MEM_DEPTH));
    old_word_s = mem_q[mem_idx_s];
  end

  load_store_align u_align (
    .funct3     (acc_funct3_s),
    .is_write   (acc_write_s),
    .addr_lo    (acc_addr_s[1:0]),
    .old_word   (old_word_s),
    .wdata      (acc_wdata_s),
    .store_word (store_word_s),
    .load_data  (load_data_s),
    .fault      (fault_s)
  );

  // Next-state, latency counter, request latch and response registers
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    commit_s     = 1'b0;
    err_s        = fault_s | oor_s;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          addr_d      = req_addr;
          write_d     = req_write;
          funct3_d    = req_funct3;
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          if (LATENCY == 1) begin
            commit_s = 1'b1;
            cnt_d    = 4'd0;
            state_d  = ST_RESP;
          end else begin
            cnt_d   = LAT_M1;
            state_d = ST_BUSY;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        req_ready_d = 1'b0;
        if (cnt_q == 4'd1) begin
          commit_s = 1'b1;
          cnt_d    = 4'd0;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        // Ready rises only once back in IDLE, so nothing is accepted in the consume cycle
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end else begin
          req_ready_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        cnt_d        = 4'd0;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
      end
    endcase
    if (commit_s) begin
      resp_valid_d = 1'b1;
      resp_error_d = err_s;
      resp_rdata_d = (!acc_write_s && !err_s) ? load_data_s : 32'h0000_0000;
    end else begin
      resp_valid_d = resp_valid_d;
    end
    mem_we_s = commit_s & acc_write_s & ~err_s;
  end

  // Control and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      funct3_q     <= 3'b000;
      wdata_q      <= 32'h0000_0000;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  // Storage array: cleared by reset, which also cancels any pending store
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (mem_we_s) begin
      mem_q[mem_idx_s] <= store_word_s;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;

endmodule

// File: tb/tb_latency_data_memory.sv
// Self-checking bench for latency_data_memory: directed vector table,
// hand-written stall/reset sequences and random traffic against a word model.
module tb_latency_data_memory;

  localparam int DEPTH = 16384;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [int unsigned];

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t tbl [19];

  latency_data_memory #(.MEM_DEPTH(DEPTH), .LATENCY(LAT), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting, expected it within 40 cycles", name);
  endtask

  // Reference: byte-addressed semantics from size, alignment and range rules
  task automatic ref_access(input logic [31:0] a, input logic w, input logic [2:0] f3,
                            input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int unsigned idx, off, size;
    logic [63:0] lowmask, mask;
    logic [31:0] word, v;
    bit uns, illegal;
    idx = a >> 2;
    off = a & 32'd3;
    uns = f3[2];
    case (f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      2'd2:    size = 4;
      default: size = 0;
    endcase
    illegal = (size == 0) || (uns && (w || size == 4));
    word = mdl.exists(idx) ? mdl[idx] : 32'h0;
    er = illegal || ((off % ((size == 0) ? 1 : size)) != 0) || (idx >= DEPTH);
    rd = 32'h0;
    if (!er) begin
      lowmask = (64'd1 << (8 * size)) - 64'd1;
      if (w) begin
        mask = lowmask << (8 * off);
        mdl[idx] = (word & ~mask[31:0]) | (32'(64'(wd) << (8 * off)) & mask[31:0]);
      end else begin
        v = 32'((64'(word) >> (8 * off)) & lowmask);
        if (!uns && size < 4 && v[8 * size - 1]) v = v | ~lowmask[31:0];
        rd = v;
      end
    end
  endtask

  // One request/response; hold>0 stalls resp_ready and drives a stray request meanwhile
  task automatic xact(input logic [31:0] a, input logic w, input logic [2:0] f3,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er);
    int n;
    int lat;
    rd = 32'h0;
    er = 1'b0;
    @(negedge clk);
    req_addr = a; req_write = w; req_funct3 = f3; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    if (!req_ready) begin timeout("req_ready"); req_valid = 1'b0; return; end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!resp_valid) begin timeout("resp_valid"); return; end
    chk("latency", 32'(lat), 32'(LAT));
    rd = resp_rdata;
    er = resp_error;
    if (hold > 0) begin
      req_addr = 32'h300; req_write = 1'b1; req_funct3 = 3'b010;
      req_wdata = 32'h1111_1111; req_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'h0, resp_valid}, 32'h1);
      chk("hold_rdata", resp_rdata, rd);
      chk("hold_req_ready", {31'h0, req_ready}, 32'h0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic model_xact(input string name, input logic [31:0] a, input logic w,
                            input logic [2:0] f3, input logic [31:0] wd, input int hold);
    logic [31:0] rd, exp_rd;
    logic er, exp_er;
    ref_access(a, w, f3, wd, exp_rd, exp_er);
    xact(a, w, f3, wd, hold, rd, er);
    chk({name, "_rdata"}, rd, exp_rd);
    chk({name, "_error"}, {31'h0, er}, {31'h0, exp_er});
  endtask

  function automatic vec_t mk(string nm, logic [31:0] a, logic w, logic [2:0] f3,
                              logic [31:0] wd, logic [31:0] rd, logic er);
    vec_t v;
    v.name = nm; v.addr = a; v.wr = w; v.f3 = f3; v.wd = wd; v.exp_rd = rd; v.exp_er = er;
    return v;
  endfunction

  initial begin
    logic [31:0] rd, drd;
    logic er, der;

    tbl[0]  = mk("sw_100",      32'h100,   1'b1, 3'b010, 32'hDEAD_BEEF, 32'h0,         1'b0);
    tbl[1]  = mk("lw_100",      32'h100,   1'b0, 3'b010, 32'h0,         32'hDEAD_BEEF, 1'b0);
    tbl[2]  = mk("lb_103",      32'h103,   1'b0, 3'b000, 32'h0,         32'hFFFF_FFDE, 1'b0);
    tbl[3]  = mk("lbu_103",     32'h103,   1'b0, 3'b100, 32'h0,         32'h0000_00DE, 1'b0);
    tbl[4]  = mk("lh_102",      32'h102,   1'b0, 3'b001, 32'h0,         32'hFFFF_DEAD, 1'b0);
    tbl[5]  = mk("lhu_100",     32'h100,   1'b0, 3'b101, 32'h0,         32'h0000_BEEF, 1'b0);
    tbl[6]  = mk("sb_101",      32'h101,   1'b1, 3'b000, 32'h55,        32'h0,         1'b0);
    tbl[7]  = mk("sh_102",      32'h102,   1'b1, 3'b001, 32'h1234,      32'h0,         1'b0);
    tbl[8]  = mk("lw_merged",   32'h100,   1'b0, 3'b010, 32'h0,         32'h1234_55EF, 1'b0);
    tbl[9]  = mk("sw_misalign", 32'h102,   1'b1, 3'b010, 32'hFFFF_FFFF, 32'h0,         1'b1);
    tbl[10] = mk("lw_unchanged",32'h100,   1'b0, 3'b010, 32'h0,         32'h1234_55EF, 1'b0);
    tbl[11] = mk("lh_misalign", 32'h101,   1'b0, 3'b001, 32'h0,         32'h0,         1'b1);
    tbl[12] = mk("lw_oor",      32'h10000, 1'b0, 3'b010, 32'h0,         32'h0,         1'b1);
    tbl[13] = mk("ld_f3_011",   32'h100,   1'b0, 3'b011, 32'h0,         32'h0,         1'b1);
    tbl[14] = mk("st_f3_100",   32'h104,   1'b1, 3'b100, 32'hFFFF_FFFF, 32'h0,         1'b1);
    tbl[15] = mk("lw_104",      32'h104,   1'b0, 3'b010, 32'h0,         32'h0,         1'b0);
    tbl[16] = mk("sw_last",     32'hFFFC,  1'b1, 3'b010, 32'hCAFE_F00D, 32'h0,         1'b0);
    tbl[17] = mk("lw_last",     32'hFFFC,  1'b0, 3'b010, 32'h0,         32'hCAFE_F00D, 1'b0);
    tbl[18] = mk("lhu_last",    32'hFFFE,  1'b0, 3'b101, 32'h0,         32'h0000_CAFE, 1'b0);

    reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_write = 1'b0;
    req_funct3 = 3'b000; req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready",  {31'h0, req_ready},  32'h0);
    chk("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("reset_resp_rdata", resp_rdata,          32'h0);
    chk("reset_resp_error", {31'h0, resp_error}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

    for (int i = 0; i < 19; i++) begin
      ref_access(tbl[i].addr, tbl[i].wr, tbl[i].f3, tbl[i].wd, drd, der);
      xact(tbl[i].addr, tbl[i].wr, tbl[i].f3, tbl[i].wd, 0, rd, er);
      chk({tbl[i].name, "_rdata"}, rd, tbl[i].exp_rd);
      chk({tbl[i].name, "_error"}, {31'h0, er}, {31'h0, tbl[i].exp_er});
    end

    // Stalled consumer: response must hold and the stray store must not be taken
    model_xact("stall_lw_100", 32'h100, 1'b0, 3'b010, 32'h0, 5);
    model_xact("lw_300_untouched", 32'h300, 1'b0, 3'b010, 32'h0, 0);

    // Reset while BUSY on a store: no write, outputs cleared
    @(negedge clk);
    req_addr = 32'h200; req_write = 1'b1; req_funct3 = 3'b010;
    req_wdata = 32'hA5A5_A5A5; req_valid = 1'b1;
    for (int n = 0; n < 40 && !req_ready; n++) @(negedge clk);
    if (!req_ready) timeout("busy_accept");
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_req_ready", {31'h0, req_ready}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_busy_req_ready",  {31'h0, req_ready},  32'h0);
    chk("rst_busy_resp_rdata", resp_rdata,          32'h0);
    chk("rst_busy_resp_error", {31'h0, resp_error}, 32'h0);
    reset = 1'b0;
    mdl.delete();
    model_xact("lw_200_after_reset", 32'h200, 1'b0, 3'b010, 32'h0, 0);
    model_xact("lw_100_cleared",     32'h100, 1'b0, 3'b010, 32'h0, 0);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = 32'h10000 + 32'($urandom_range(0, 255));
      else a = 32'($urandom_range(0, 255));
      model_xact("rand", a, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 $urandom, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
